// File: rtl/pc_src_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_src_ctrl_pkg
// Description : Shared PC-source select encodings and MIPS op/func/rt
//               literals used by the next-PC source controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_src_ctrl_pkg;

    // Next-PC source selects (the controller register is SEL_W wide).
    typedef enum logic [2:0] {
        PC_ADD4 = 3'd0,
        PC_NPC  = 3'd1,
        PC_RD1  = 3'd2,
        PC_EPC  = 3'd3,
        PC_EXC  = 3'd4
    } pc_sel_e;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] SPECIAL = 6'b000000;
    localparam logic [5:0] REGIMM  = 6'b000001;
    localparam logic [5:0] J       = 6'b000010;
    localparam logic [5:0] JAL     = 6'b000011;
    localparam logic [5:0] BEQ     = 6'b000100;
    localparam logic [5:0] BNE     = 6'b000101;
    localparam logic [5:0] BLEZ    = 6'b000110;
    localparam logic [5:0] BGTZ    = 6'b000111;
    localparam logic [5:0] COP0    = 6'b010000;

    // Function codes, instruction[5:0]
    localparam logic [5:0] JR      = 6'b001000;
    localparam logic [5:0] JALR    = 6'b001001;
    localparam logic [5:0] ERET    = 6'b011000;

    // REGIMM rt selectors, instruction[20:16]
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

endpackage
`default_nettype wire

// File: rtl/pc_src_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_src_ctrl_if
// Description : Decode inputs and registered outputs of the next-PC source
//               controller. The fetch/decode side drives through master, the
//               controller attaches through slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_src_ctrl_if #(
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = 3
);
    logic [5:0]              op;
    logic [5:0]              func;
    logic [4:0]              rt;
    logic                    zero;
    logic                    rs_neg;
    logic                    rs_zero;
    logic                    stall;
    logic                    exc_req;
    logic [SEL_W-1:0]        pc_sel;
    logic [6*PIPE_DEPTH-1:0] op_q;
    logic [6*PIPE_DEPTH-1:0] func_q;
    logic [PIPE_DEPTH-1:0]   valid_q;
    logic [CNT_W-1:0]        redirect_cnt;

    modport master (
        output op, func, rt, zero, rs_neg, rs_zero, stall, exc_req,
        input  pc_sel, op_q, func_q, valid_q, redirect_cnt
    );

    modport slave (
        input  op, func, rt, zero, rs_neg, rs_zero, stall, exc_req,
        output pc_sel, op_q, func_q, valid_q, redirect_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pc_src_ctrl_branch_decode.sv
`default_nettype none
// ============================================================================
// Module      : branch_decode
// Description : Combinational map from the current instruction fields and
//               comparator flags to the next-PC source select.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_decode
    import pc_src_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic [4:0] rt,
    input  logic       zero,
    input  logic       rs_neg,
    input  logic       rs_zero,
    output pc_sel_e    sel
);

    // Anything not recognised falls through to sequential fetch.
    always_comb begin
        sel = PC_ADD4;
        case (op)
            BEQ:     if (zero)                 sel = PC_NPC;
            BNE:     if (!zero)                sel = PC_NPC;
            BLEZ:    if (rs_neg || rs_zero)    sel = PC_NPC;
            BGTZ:    if (!rs_neg && !rs_zero)  sel = PC_NPC;
            REGIMM:  if ((rt == RT_BLTZ &&  rs_neg) ||
                         (rt == RT_BGEZ && !rs_neg)) sel = PC_NPC;
            J, JAL:                            sel = PC_NPC;
            SPECIAL: if (func == JR || func == JALR) sel = PC_RD1;
            COP0:    if (func == ERET)         sel = PC_EPC;
            default:                           sel = PC_ADD4;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_src_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_src_ctrl
// Description : Registered next-PC source controller. Registers the decoded
//               PC select, carries op/func/valid down a shadow pipeline with
//               stall and exception bubbling, and counts taken redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_src_ctrl
    import pc_src_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = 3
) (
    input  logic            clk,
    input  logic            reset,
    pc_src_ctrl_if.slave    bus
);

    pc_sel_e          w_dec;
    logic [SEL_W-1:0] r_pc_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_op    [PIPE_DEPTH];
    logic [5:0]       r_func  [PIPE_DEPTH];
    logic             r_valid [PIPE_DEPTH];

    branch_decode u_decode (
        .op      (bus.op),
        .func    (bus.func),
        .rt      (bus.rt),
        .zero    (bus.zero),
        .rs_neg  (bus.rs_neg),
        .rs_zero (bus.rs_zero),
        .sel     (w_dec)
    );

    // PC select register: exception vector wins over stall, stall holds.
    always_ff @(posedge clk) begin
        if (reset)
            r_pc_sel <= SEL_W'(PC_ADD4);
        else if (bus.exc_req)
            r_pc_sel <= SEL_W'(PC_EXC);
        else if (!bus.stall)
            r_pc_sel <= SEL_W'(w_dec);
    end

    // Redirect counter: every exception and every non-sequential select
    // committed in a normal cycle; wraps freely.
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (bus.exc_req)
            r_cnt <= r_cnt + CNT_W'(1);
        else if (!bus.stall && w_dec != PC_ADD4)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            // Stage 0: bubbled by exceptions, held by stall, else loads.
            always_ff @(posedge clk) begin
                if (reset || bus.exc_req) begin
                    r_op[0]    <= '0;
                    r_func[0]  <= '0;
                    r_valid[0] <= 1'b0;
                end else if (!bus.stall) begin
                    r_op[0]    <= bus.op;
                    r_func[0]  <= bus.func;
                    r_valid[0] <= 1'b1;
                end
            end
        end else if (k == 1) begin : g_second
            // Stage 1: takes a bubble whenever stage 0 does not advance.
            always_ff @(posedge clk) begin
                if (reset || bus.exc_req || bus.stall) begin
                    r_op[1]    <= '0;
                    r_func[1]  <= '0;
                    r_valid[1] <= 1'b0;
                end else begin
                    r_op[1]    <= r_op[0];
                    r_func[1]  <= r_func[0];
                    r_valid[1] <= r_valid[0];
                end
            end
        end else begin : g_tail
            // Deeper stages always drain downstream.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_op[k]    <= '0;
                    r_func[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end else begin
                    r_op[k]    <= r_op[k-1];
                    r_func[k]  <= r_func[k-1];
                    r_valid[k] <= r_valid[k-1];
                end
            end
        end

        assign bus.op_q[6*k +: 6]   = r_op[k];
        assign bus.func_q[6*k +: 6] = r_func[k];
        assign bus.valid_q[k]       = r_valid[k];
    end

    assign bus.pc_sel       = r_pc_sel;
    assign bus.redirect_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_src_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_src_ctrl
// Description : Self-checking bench for pc_src_ctrl. Two instances share the
//               same stimulus: a default one (depth 3, 16-bit counter) and a
//               small one (depth 1, 2-bit counter). Both are tracked by a
//               stage-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_src_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, func;
    logic [4:0] rt;
    logic       zero, rs_neg, rs_zero, stall, exc_req;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pc_src_ctrl_if #(.PIPE_DEPTH(3), .CNT_W(16), .SEL_W(3)) bus_a ();
    pc_src_ctrl_if #(.PIPE_DEPTH(1), .CNT_W(2),  .SEL_W(3)) bus_b ();

    assign bus_a.op = op;      assign bus_b.op = op;
    assign bus_a.func = func;  assign bus_b.func = func;
    assign bus_a.rt = rt;      assign bus_b.rt = rt;
    assign bus_a.zero = zero;  assign bus_b.zero = zero;
    assign bus_a.rs_neg = rs_neg;   assign bus_b.rs_neg = rs_neg;
    assign bus_a.rs_zero = rs_zero; assign bus_b.rs_zero = rs_zero;
    assign bus_a.stall = stall;     assign bus_b.stall = stall;
    assign bus_a.exc_req = exc_req; assign bus_b.exc_req = exc_req;

    pc_src_ctrl #(.PIPE_DEPTH(3), .CNT_W(16), .SEL_W(3)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    pc_src_ctrl #(.PIPE_DEPTH(1), .CNT_W(2), .SEL_W(3)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    // ---------------- reference model ----------------
    // Index 0 models bus_a, index 1 models bus_b.
    int          m_depth [2] = '{3, 1};
    int unsigned m_mod   [2] = '{65536, 4};
    int unsigned m_sel   [2];
    int unsigned m_cnt   [2];
    int unsigned m_op    [2][3];
    int unsigned m_func  [2][3];
    int unsigned m_val   [2][3];

    // Next-PC source from the instruction rules: 0 seq, 1 branch/jump
    // target, 2 register, 3 EPC.
    function automatic int unsigned ref_decode(int unsigned o, int unsigned f,
                                               int unsigned r, bit z, bit n, bit rz);
        bit taken = 0;
        if (o == 4)      taken = z;
        else if (o == 5) taken = !z;
        else if (o == 6) taken = n || rz;
        else if (o == 7) taken = !n && !rz;
        else if (o == 1) taken = (r == 0 && n) || (r == 1 && !n);
        else if (o == 2 || o == 3) taken = 1;
        if (taken) return 1;
        if (o == 0 && (f == 8 || f == 9)) return 2;
        if (o == 16 && f == 24) return 3;
        return 0;
    endfunction

    task automatic model_step(input int i);
        int unsigned d;
        int unsigned nop  [3];
        int unsigned nfun [3];
        int unsigned nval [3];
        d = ref_decode(op, func, rt, zero, rs_neg, rs_zero);
        // every stage's default next value is its upstream neighbour
        for (int k = 0; k < 3; k++) begin
            nop[k]  = (k == 0) ? m_op[i][0]  : m_op[i][k-1];
            nfun[k] = (k == 0) ? m_func[i][0] : m_func[i][k-1];
            nval[k] = (k == 0) ? m_val[i][0] : m_val[i][k-1];
        end
        if (reset) begin
            m_sel[i] = 0; m_cnt[i] = 0;
            for (int k = 0; k < 3; k++) begin nop[k] = 0; nfun[k] = 0; nval[k] = 0; end
        end else if (exc_req) begin
            m_sel[i] = 4;
            m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
            for (int k = 0; k < 2; k++) begin nop[k] = 0; nfun[k] = 0; nval[k] = 0; end
        end else if (stall) begin
            nop[1] = 0; nfun[1] = 0; nval[1] = 0;   // stage 0 keeps its value
        end else begin
            m_sel[i] = d;
            if (d != 0) m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
            nop[0] = op; nfun[0] = func; nval[0] = 1;
        end
        for (int k = 0; k < 3; k++) begin
            if (k < m_depth[i]) begin
                m_op[i][k] = nop[k]; m_func[i][k] = nfun[k]; m_val[i][k] = nval[k];
            end else begin
                m_op[i][k] = 0; m_func[i][k] = 0; m_val[i][k] = 0;
            end
        end
    endtask

    function automatic logic [63:0] pack6(int i, bit use_func);
        logic [63:0] v = '0;
        for (int k = 0; k < 3; k++)
            v = v | (64'(use_func ? m_func[i][k] : m_op[i][k]) << (6 * k));
        return v;
    endfunction

    function automatic logic [63:0] packv(int i);
        logic [63:0] v = '0;
        for (int k = 0; k < 3; k++)
            v = v | (64'(m_val[i][k]) << k);
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic compare_model(input string tag);
        check({tag, " a.pc_sel"},  64'(bus_a.pc_sel),       64'(m_sel[0]));
        check({tag, " a.op_q"},    64'(bus_a.op_q),         pack6(0, 0));
        check({tag, " a.func_q"},  64'(bus_a.func_q),       pack6(0, 1));
        check({tag, " a.valid_q"}, 64'(bus_a.valid_q),      packv(0));
        check({tag, " a.cnt"},     64'(bus_a.redirect_cnt), 64'(m_cnt[0]));
        check({tag, " b.pc_sel"},  64'(bus_b.pc_sel),       64'(m_sel[1]));
        check({tag, " b.op_q"},    64'(bus_b.op_q),         pack6(1, 0));
        check({tag, " b.func_q"},  64'(bus_b.func_q),       pack6(1, 1));
        check({tag, " b.valid_q"}, 64'(bus_b.valid_q),      packv(1));
        check({tag, " b.cnt"},     64'(bus_b.redirect_cnt), 64'(m_cnt[1]));
    endtask

    // One clock: inputs already set, model follows the edge, compare at +1.
    task automatic step(input string tag);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_model(tag);
    endtask

    task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                          input logic z, input logic n, input logic rz,
                          input logic st, input logic ex);
        op = o; func = f; rt = r; zero = z; rs_neg = n; rs_zero = rz;
        stall = st; exc_req = ex;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        set_in(6'h00, 6'h00, 5'd0, 0, 0, 0, 0, 0);
        for (int c = 0; c < cycles; c++) step("reset");
        reset = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic [4:0] rt;
        logic       zero, rs_neg, rs_zero, exc;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(logic [5:0] o, logic [5:0] f, logic [4:0] r,
                                logic z, logic n, logic rz, logic ex, logic [2:0] s);
        vec_t v;
        v.op = o; v.func = f; v.rt = r; v.zero = z; v.rs_neg = n;
        v.rs_zero = rz; v.exc = ex; v.exp_sel = s;
        return v;
    endfunction

    logic [5:0]  rops  [10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                                6'h05, 6'h06, 6'h07, 6'h10, 6'h23};
    logic [5:0]  rfun  [5]  = '{6'h08, 6'h09, 6'h18, 6'h21, 6'h00};
    int unsigned cnt_before;

    initial begin
        reset = 1'b1;
        set_in(6'h00, 6'h00, 5'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            m_sel[i] = 0; m_cnt[i] = 0;
            for (int k = 0; k < 3; k++) begin m_op[i][k] = 0; m_func[i][k] = 0; m_val[i][k] = 0; end
        end

        //                op     func   rt  z  n  rz ex  sel
        tbl.push_back(mk(6'h00, 6'h21, 0, 0, 0, 0, 0, 3'd0)); // addu
        tbl.push_back(mk(6'h04, 6'h00, 0, 1, 0, 0, 0, 3'd1)); // beq taken
        tbl.push_back(mk(6'h04, 6'h00, 0, 0, 0, 0, 0, 3'd0)); // beq not taken
        tbl.push_back(mk(6'h05, 6'h00, 0, 1, 0, 0, 0, 3'd0)); // bne not taken
        tbl.push_back(mk(6'h05, 6'h00, 0, 0, 0, 0, 0, 3'd1)); // bne taken
        tbl.push_back(mk(6'h06, 6'h00, 0, 0, 1, 0, 0, 3'd1)); // blez negative
        tbl.push_back(mk(6'h06, 6'h00, 0, 0, 0, 1, 0, 3'd1)); // blez zero
        tbl.push_back(mk(6'h06, 6'h00, 0, 0, 0, 0, 0, 3'd0)); // blez positive
        tbl.push_back(mk(6'h07, 6'h00, 0, 0, 0, 0, 0, 3'd1)); // bgtz positive
        tbl.push_back(mk(6'h07, 6'h00, 0, 0, 0, 1, 0, 3'd0)); // bgtz zero
        tbl.push_back(mk(6'h01, 6'h00, 0, 0, 1, 0, 0, 3'd1)); // bltz taken
        tbl.push_back(mk(6'h01, 6'h00, 0, 0, 0, 0, 0, 3'd0)); // bltz not taken
        tbl.push_back(mk(6'h01, 6'h00, 1, 0, 0, 0, 0, 3'd1)); // bgez taken
        tbl.push_back(mk(6'h01, 6'h00, 1, 0, 1, 0, 0, 3'd0)); // bgez not taken
        tbl.push_back(mk(6'h01, 6'h00, 2, 0, 1, 0, 0, 3'd0)); // unknown regimm
        tbl.push_back(mk(6'h02, 6'h00, 0, 0, 0, 0, 0, 3'd1)); // j
        tbl.push_back(mk(6'h03, 6'h00, 0, 0, 0, 0, 0, 3'd1)); // jal
        tbl.push_back(mk(6'h00, 6'h08, 0, 0, 0, 0, 0, 3'd2)); // jr
        tbl.push_back(mk(6'h00, 6'h09, 0, 0, 0, 0, 0, 3'd2)); // jalr
        tbl.push_back(mk(6'h10, 6'h18, 0, 0, 0, 0, 0, 3'd3)); // eret
        tbl.push_back(mk(6'h10, 6'h00, 0, 0, 0, 0, 0, 3'd0)); // other cop0
        tbl.push_back(mk(6'h00, 6'h08, 0, 0, 0, 0, 1, 3'd4)); // exception over jr
        tbl.push_back(mk(6'h23, 6'h08, 0, 1, 1, 1, 0, 3'd0)); // lw

        // Reset, then addu fills the pipe one stage per cycle.
        do_reset(2);
        check("reset pc_sel", 64'(bus_a.pc_sel), 64'd0);
        check("reset valid_q", 64'(bus_a.valid_q), 64'd0);
        check("reset cnt", 64'(bus_a.redirect_cnt), 64'd0);
        set_in(6'h00, 6'h21, 5'd0, 0, 0, 0, 0, 0);
        step("fill1"); check("fill1 valid_q", 64'(bus_a.valid_q), 64'b001);
        step("fill2"); check("fill2 valid_q", 64'(bus_a.valid_q), 64'b011);
        step("fill3"); check("fill3 valid_q", 64'(bus_a.valid_q), 64'b111);
        check("fill pc_sel", 64'(bus_a.pc_sel), 64'd0);
        check("fill cnt", 64'(bus_a.redirect_cnt), 64'd0);

        // Test-plan branch sequence: cnt reaches 3.
        set_in(6'h04, 6'h00, 5'd0, 1, 0, 0, 0, 0); step("beq");
        check("beq pc_sel", 64'(bus_a.pc_sel), 64'd1);
        check("beq cnt", 64'(bus_a.redirect_cnt), 64'd1);
        set_in(6'h05, 6'h00, 5'd0, 1, 0, 0, 0, 0); step("bne");
        check("bne pc_sel", 64'(bus_a.pc_sel), 64'd0);
        set_in(6'h01, 6'h00, 5'd1, 0, 0, 0, 0, 0); step("bgez");
        check("bgez pc_sel", 64'(bus_a.pc_sel), 64'd1);
        set_in(6'h06, 6'h00, 5'd0, 0, 0, 1, 0, 0); step("blez");
        check("blez pc_sel", 64'(bus_a.pc_sel), 64'd1);
        check("branch seq cnt", 64'(bus_a.redirect_cnt), 64'd3);

        // Table of single-cycle decodes.
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].op, tbl[i].func, tbl[i].rt, tbl[i].zero, tbl[i].rs_neg,
                   tbl[i].rs_zero, 1'b0, tbl[i].exc);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d pc_sel", i), 64'(bus_a.pc_sel), 64'(tbl[i].exp_sel));
        end

        // j then two stalled cycles with op changed underneath.
        set_in(6'h02, 6'h00, 5'd0, 0, 0, 0, 0, 0);
        cnt_before = m_cnt[0];
        step("j");
        set_in(6'h00, 6'h00, 5'd0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 2; c++) begin
            step("stall");
            check("stall pc_sel", 64'(bus_a.pc_sel), 64'd1);
            check("stall op_q[5:0]", 64'(bus_a.op_q[5:0]), 64'h02);
            check("stall valid_q[1]", 64'(bus_a.valid_q[1]), 64'd0);
            check("stall b.op_q", 64'(bus_b.op_q), 64'h02);
        end
        check("stall cnt", 64'(bus_a.redirect_cnt), 64'((cnt_before + 1) % 65536));

        // Exception while stalled.
        cnt_before = m_cnt[0];
        set_in(6'h00, 6'h08, 5'd0, 0, 0, 0, 1, 1); step("exc+stall");
        check("exc pc_sel", 64'(bus_a.pc_sel), 64'd4);
        check("exc valid_q[1:0]", 64'(bus_a.valid_q[1:0]), 64'd0);
        check("exc b.valid_q", 64'(bus_b.valid_q), 64'd0);
        check("exc cnt", 64'(bus_a.redirect_cnt), 64'((cnt_before + 1) % 65536));

        // Reset asserted on top of stall and exception clears everything.
        reset = 1'b1; step("mid reset");
        check("mid reset a.pc_sel", 64'(bus_a.pc_sel), 64'd0);
        check("mid reset a.op_q", 64'(bus_a.op_q), 64'd0);
        check("mid reset a.valid_q", 64'(bus_a.valid_q), 64'd0);
        check("mid reset a.cnt", 64'(bus_a.redirect_cnt), 64'd0);
        check("mid reset b.cnt", 64'(bus_b.redirect_cnt), 64'd0);
        reset = 1'b0;

        // Five jumps: 2-bit counter wraps to 1.
        set_in(6'h02, 6'h00, 5'd0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) step("wrap");
        check("wrap b.cnt", 64'(bus_b.redirect_cnt), 64'd1);
        check("wrap a.cnt", 64'(bus_a.redirect_cnt), 64'd5);

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) < 3);
            set_in(rops[$urandom_range(0, 9)],
                   ($urandom_range(0, 3) == 0) ? 6'($urandom) : rfun[$urandom_range(0, 4)],
                   5'($urandom_range(0, 2)),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 8));
            step("rand");
        end

        reset = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
